eth_mii_rx_deframer: RTL

Receive-side MII deframer for the 100 Mbps Ethernet user-project datapath. It consumes the PHY's 4-bit MII receive nibbles (`phy_rxd`/`phy_rx_dv`/`phy_rx_er` on the user IOs), removes preamble/SFD, assembles bytes, strips the 4-byte FCS and flags bad frames. It emits a byte stream with last/error sideband to the downstream MAC/UDP receive logic. No backpressure: MII cannot stall.

---
 rtl/eth_mii_pkg.sv | 28 ++
 rtl/eth_crc32_byte.sv | 22 ++
 rtl/eth_mii_rx_deframer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/eth_mii_pkg.sv
// Shared types and constants for the MII receive deframer and its CRC helper.
package eth_mii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_t;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    // Normal-form polynomial; the LSB-first shifter uses its bit reversal.
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam int unsigned FCS_LEN       = 4;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update, one byte (LSB first) per evaluation.
module eth_crc32_byte
    import eth_mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD/FCS and flags bad frames.
// Define ETH_RX_CRC_CHECK_EN to build the CRC residue check.
module eth_mii_rx_deframer
    import eth_mii_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       stat_frame_good,
    output logic       stat_frame_bad
);

    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_LEN + 1);

    rx_state_t state_q, state_d;
    logic start_frame, nib_valid, end_frame;

    logic             phase_q;
    logic [3:0]       low_nib_q;
    logic [LEN_W-1:0] len_q;
    logic             err_q;
    logic [7:0]       dl_q [FCS_LEN];
    logic [FCS_LEN-1:0] dl_vld_q;
    logic [7:0]       hold_q;
    logic             hold_vld_q;
    logic [7:0]       byte_new;
    logic             crc_bad;
    logic             frame_bad;

    assign byte_new = {mii_rxd, low_nib_q};

`ifdef ETH_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_upd;

    eth_crc32_byte u_crc (
        .crc_in (crc_q),
        .data   (byte_new),
        .crc_out(crc_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
        end else if (start_frame) begin
            crc_q <= CRC32_INIT;
        end else if (nib_valid && phase_q) begin
            crc_q <= crc_upd;
        end
    end

    assign crc_bad = (reflect32(crc_q) != CRC32_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    assign frame_bad = err_q | phase_q | (len_q < LEN_MIN) | (len_q > LEN_MAX) | crc_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        nib_valid   = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mii_rx_dv) begin
                    state_d = (mii_rxd == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (mii_rx_er) begin
                    state_d = ST_DROP;
                end else if (mii_rxd == SFD_NIB) begin
                    state_d     = ST_PAYLOAD;
                    start_frame = 1'b1;
                end else if (mii_rxd != PREAMBLE_NIB) begin
                    state_d = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (mii_rx_dv) begin
                    nib_valid = 1'b1;
                end else begin
                    end_frame = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!mii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q         <= 1'b0;
            low_nib_q       <= '0;
            len_q           <= '0;
            err_q           <= 1'b0;
            dl_vld_q        <= '0;
            hold_q          <= '0;
            hold_vld_q      <= 1'b0;
            m_tdata         <= '0;
            m_tvalid        <= 1'b0;
            m_tlast         <= 1'b0;
            m_tuser         <= 1'b0;
            stat_frame_good <= 1'b0;
            stat_frame_bad  <= 1'b0;
            for (int unsigned i = 0; i < FCS_LEN; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            m_tvalid        <= 1'b0;
            m_tlast         <= 1'b0;
            m_tuser         <= 1'b0;
            stat_frame_good <= 1'b0;
            stat_frame_bad  <= 1'b0;

            if (start_frame) begin
                phase_q    <= 1'b0;
                len_q      <= '0;
                err_q      <= 1'b0;
                dl_vld_q   <= '0;
                hold_vld_q <= 1'b0;
            end

            if (nib_valid) begin
                phase_q <= ~phase_q;
                if (mii_rx_er) begin
                    err_q <= 1'b1;
                end
                if (!phase_q) begin
                    low_nib_q <= mii_rxd;
                end else begin
                    // Hold byte leaves now; the four newest bytes stay back as FCS candidates.
                    if (hold_vld_q) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= hold_q;
                    end
                    hold_q     <= dl_q[0];
                    hold_vld_q <= dl_vld_q[0];
                    for (int unsigned i = 0; i < FCS_LEN - 1; i++) begin
                        dl_q[i] <= dl_q[i+1];
                    end
                    dl_q[FCS_LEN-1] <= byte_new;
                    dl_vld_q        <= {1'b1, dl_vld_q[FCS_LEN-1:1]};
                    if (len_q != LEN_SAT) begin
                        len_q <= len_q + 1'b1;
                    end
                end
            end

            if (end_frame) begin
                if (hold_vld_q) begin
                    m_tvalid <= 1'b1;
                    m_tlast  <= 1'b1;
                    m_tuser  <= frame_bad;
                    m_tdata  <= hold_q;
                end
                stat_frame_good <= ~frame_bad;
                stat_frame_bad  <= frame_bad;
                hold_vld_q      <= 1'b0;
                dl_vld_q        <= '0;
            end
        end
    end

endmodule
